// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM handshake state, machine word and arbiter FSM.
package cpu_types_pkg;
  localparam int WORD_BITS = 32;

  typedef logic [WORD_BITS-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  // Kind of the granted request: data vs instruction side, write vs read.
  typedef struct packed {
    logic dside;
    logic wr;
  } src_t;
endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin selector: first requester at or after rr, wrapping.
module rr_picker #(
  parameter int CPUS = 2,
  parameter int PW   = 1
) (
  input  logic [CPUS-1:0] req,
  input  logic [PW-1:0]   rr,
  output logic [PW-1:0]   idx,
  output logic            vld
);
  logic [2*CPUS-1:0] dbl;
  logic [CPUS-1:0]   rot;
  logic [PW:0]       sum;

  // Rotate so rr sits at bit 0, take the lowest set bit, map back to a core index.
  always_comb begin
    dbl = {req, req} >> rr;
    rot = dbl[CPUS-1:0];
    vld = |rot;
    sum = '0;
    for (int k = CPUS-1; k >= 0; k--) begin
      if (rot[k]) sum = {1'b0, rr} + (PW+1)'(k);
    end
    if (sum >= (PW+1)'(CPUS)) sum = sum - (PW+1)'(CPUS);
    idx = sum[PW-1:0];
  end
endmodule

// File: rtl/mem_arbiter.sv
// Multi-core memory arbiter: one granted cache request at a time onto a single-ported RAM.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS   = 2,
  parameter int WORD_W = 32
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic [CPUS-1:0]              iREN,
  input  logic [CPUS-1:0]              dREN,
  input  logic [CPUS-1:0]              dWEN,
  input  logic [CPUS-1:0][WORD_W-1:0]  iaddr,
  input  logic [CPUS-1:0][WORD_W-1:0]  daddr,
  input  logic [CPUS-1:0][WORD_W-1:0]  dstore,
  output logic [CPUS-1:0]              iwait,
  output logic [CPUS-1:0]              dwait,
  output logic [CPUS-1:0][WORD_W-1:0]  iload,
  output logic [CPUS-1:0][WORD_W-1:0]  dload,
  output logic                         ramREN,
  output logic                         ramWEN,
  output logic [WORD_W-1:0]            ramaddr,
  output logic [WORD_W-1:0]            ramstore,
  input  logic [WORD_W-1:0]            ramload,
  input  ramstate_t                    ramstate
);
  localparam int PW = (CPUS > 1) ? $clog2(CPUS) : 1;

  arb_state_t      state;
  logic [PW-1:0]   rr, gcore, win, rr_nxt;
  src_t            gsrc;
  logic [CPUS-1:0] creq;
  logic            win_vld, still, done;

  for (genvar c = 0; c < CPUS; c++) begin : g_req
    assign creq[c] = iREN[c] | dREN[c] | dWEN[c];
  end

  rr_picker #(.CPUS(CPUS), .PW(PW)) u_pick (
    .req (creq),
    .rr  (rr),
    .idx (win),
    .vld (win_vld)
  );

  // Granted source still asking; a drop means abort, and ACCESS only completes while held.
  always_comb begin
    still  = gsrc.dside ? (gsrc.wr ? dWEN[gcore] : dREN[gcore]) : iREN[gcore];
    done   = (state == XFER) && still && (ramstate == ACCESS);
    rr_nxt = (gcore == PW'(CPUS-1)) ? '0 : gcore + PW'(1);
  end

  // Grant/transfer FSM; RAM side is driven only from registers latched at grant.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      rr       <= '0;
      gcore    <= '0;
      gsrc     <= '0;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= '0;
      ramstore <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            gcore <= win;
            state <= XFER;
            if (dWEN[win]) begin
              gsrc     <= '{dside: 1'b1, wr: 1'b1};
              ramWEN   <= 1'b1;
              ramaddr  <= daddr[win];
              ramstore <= dstore[win];
            end else if (dREN[win]) begin
              gsrc     <= '{dside: 1'b1, wr: 1'b0};
              ramREN   <= 1'b1;
              ramaddr  <= daddr[win];
              ramstore <= dstore[win];
            end else begin
              gsrc     <= '{dside: 1'b0, wr: 1'b0};
              ramREN   <= 1'b1;
              ramaddr  <= iaddr[win];
              ramstore <= '0;
            end
          end
        end
        XFER: begin
          // FREE/BUSY/ERROR keep the request on the bus; ERROR is simply reissued.
          if (!still || ramstate == ACCESS) begin
            state  <= IDLE;
            ramREN <= 1'b0;
            ramWEN <= 1'b0;
            if (still) rr <= rr_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Only the granted source sees wait low / load data, and only in its ACCESS cycle.
  always_comb begin
    iwait = '1;
    dwait = '1;
    iload = '0;
    dload = '0;
    if (done) begin
      if (gsrc.dside) begin
        dwait[gcore] = 1'b0;
        if (!gsrc.wr) dload[gcore] = ramload;
      end else begin
        iwait[gcore] = 1'b0;
        iload[gcore] = ramload;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic vs a transaction model.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int CPUS = 2;
  localparam int W    = 32;

  logic                   CLK = 1'b0;
  logic                   nRST = 1'b0;
  logic [CPUS-1:0]        iREN, dREN, dWEN;
  logic [CPUS-1:0][W-1:0] iaddr, daddr, dstore;
  logic [CPUS-1:0]        iwait, dwait;
  logic [CPUS-1:0][W-1:0] iload, dload;
  logic                   ramREN, ramWEN;
  logic [W-1:0]           ramaddr, ramstore, ramload;
  ramstate_t              ramstate;

  always #5 CLK = ~CLK;

  mem_arbiter #(.CPUS(CPUS), .WORD_W(W)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
    .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  int n_chk = 0;
  int n_err = 0;
  int n_obs = 0;

  task automatic chk(string tag, logic [W-1:0] act, logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Transaction-level reference: the one outstanding access and the next-priority core.
  bit          m_busy;
  int          m_core;
  bit          m_d, m_wr;
  logic [W-1:0] m_addr, m_store;
  int          m_rr;

  // One clock: compare at negedge against the model, advance the model, land #1 after posedge.
  task automatic tick();
    logic                   still, done;
    logic [CPUS-1:0]        ei, ed;
    logic [CPUS-1:0][W-1:0] eil, edl;
    int                     c;
    bit                     found;
    @(negedge CLK);
    still = 1'b0;
    if (m_busy) still = m_d ? (m_wr ? dWEN[m_core] : dREN[m_core]) : iREN[m_core];
    done = m_busy && still && (ramstate == ACCESS);
    ei = '1; ed = '1; eil = '0; edl = '0;
    if (done) begin
      if (m_d) begin
        ed[m_core] = 1'b0;
        if (!m_wr) edl[m_core] = ramload;
      end else begin
        ei[m_core]  = 1'b0;
        eil[m_core] = ramload;
      end
    end
    if (iwait !== '1 || dwait !== '1) n_obs++;
    chk("iwait", W'(iwait), W'(ei));
    chk("dwait", W'(dwait), W'(ed));
    for (int k = 0; k < CPUS; k++) begin
      chk($sformatf("iload%0d", k), iload[k], eil[k]);
      chk($sformatf("dload%0d", k), dload[k], edl[k]);
    end
    chk("ramREN", W'(ramREN), W'(m_busy && !m_wr));
    chk("ramWEN", W'(ramWEN), W'(m_busy && m_wr));
    if (m_busy) chk("ramaddr", ramaddr, m_addr);
    if (m_busy && m_wr) chk("ramstore", ramstore, m_store);
    if (m_busy) begin
      if (!still) m_busy = 1'b0;
      else if (ramstate == ACCESS) begin
        m_busy = 1'b0;
        m_rr   = (m_core + 1) % CPUS;
      end
    end else begin
      found = 1'b0;
      for (int k = 0; k < CPUS; k++) begin
        c = (m_rr + k) % CPUS;
        if (!found && (iREN[c] || dREN[c] || dWEN[c])) begin
          found   = 1'b1;
          m_busy  = 1'b1;
          m_core  = c;
          m_d     = dREN[c] || dWEN[c];
          m_wr    = dWEN[c];
          m_addr  = m_d ? daddr[c] : iaddr[c];
          m_store = dstore[c];
        end
      end
    end
    @(posedge CLK);
    #1;
  endtask

  // From an idle cycle with ACCESS on the RAM: grant, then complete with the given wait pattern.
  task automatic slot(logic [CPUS-1:0] ei, logic [CPUS-1:0] ed);
    #1;
    chk("slot_idle_iw", W'(iwait), W'(2'b11));
    chk("slot_idle_dw", W'(dwait), W'(2'b11));
    chk("slot_idle_ren", W'(ramREN | ramWEN), W'(1'b0));
    tick();
    chk("slot_iw", W'(iwait), W'(ei));
    chk("slot_dw", W'(dwait), W'(ed));
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    int obs0, r;
    iREN = '0; dREN = '0; dWEN = '0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramload = '0; ramstate = FREE;
    m_busy = 0; m_rr = 0; m_core = 0; m_d = 0; m_wr = 0; m_addr = '0; m_store = '0;

    // reset state
    #2;
    chk("rst_ren", W'(ramREN), 0);
    chk("rst_wen", W'(ramWEN), 0);
    chk("rst_addr", ramaddr, 0);
    chk("rst_store", ramstore, 0);
    chk("rst_iwait", W'(iwait), W'(2'b11));
    chk("rst_dwait", W'(dwait), W'(2'b11));
    chk("rst_iload", iload[0] | iload[1], 0);
    chk("rst_dload", dload[0] | dload[1], 0);
    @(posedge CLK); #1;
    nRST = 1'b1;
    tick();

    // single read, latency 2
    iREN = 2'b01; iaddr[0] = 32'h40; ramstate = FREE;
    tick();
    ramstate = BUSY; #1;
    chk("rd_ren", W'(ramREN), 1);
    chk("rd_addr", ramaddr, 32'h40);
    chk("rd_wait_busy", W'(iwait), W'(2'b11));
    tick();
    ramstate = ACCESS; ramload = 32'hDEADBEEF; #1;
    chk("rd_wait_acc", W'(iwait), W'(2'b10));
    chk("rd_load", iload[0], 32'hDEADBEEF);
    tick();
    iREN = '0; ramstate = FREE; #1;
    chk("rd_wait_after", W'(iwait), W'(2'b11));
    chk("rd_load_after", iload[0], 0);
    chk("rd_ren_after", W'(ramREN), 0);
    tick();

    // bring rr back to 0 via a core1 fetch
    iREN = 2'b10; iaddr[1] = 32'h80; ramstate = ACCESS;
    slot(2'b01, 2'b11);
    iREN = '0;

    // contention from rr=0: alternation 0,1,0
    dREN = 2'b11; daddr[0] = 32'h100; daddr[1] = 32'h104;
    slot(2'b11, 2'b10);
    slot(2'b11, 2'b01);
    slot(2'b11, 2'b10);
    dREN = '0;
    tick();
    // repeat with rr=1: core1 first
    dREN = 2'b11;
    slot(2'b11, 2'b01);
    dREN = '0;
    tick();

    // same-core priority: write before fetch
    iREN = 2'b10; dWEN = 2'b10; daddr[1] = 32'h200; dstore[1] = 32'h1234; ramstate = FREE;
    tick();
    ramstate = ACCESS; #1;
    chk("pri_wen", W'(ramWEN), 1);
    chk("pri_ren", W'(ramREN), 0);
    chk("pri_addr", ramaddr, 32'h200);
    chk("pri_store", ramstore, 32'h1234);
    chk("pri_dwait", W'(dwait), W'(2'b01));
    chk("pri_iwait", W'(iwait), W'(2'b11));
    tick();
    dWEN = '0;
    tick();
    #1;
    chk("pri_fetch_ren", W'(ramREN), 1);
    chk("pri_fetch_addr", ramaddr, 32'h80);
    chk("pri_fetch_iw", W'(iwait), W'(2'b01));
    tick();
    iREN = '0;
    tick();

    // error retry: ERROR x3 then ACCESS, one completion
    dREN = 2'b01; daddr[0] = 32'h300; ramstate = FREE;
    tick();
    obs0 = n_obs;
    ramstate = ERROR;
    repeat (3) begin
      #1;
      chk("err_ren", W'(ramREN), 1);
      chk("err_addr", ramaddr, 32'h300);
      chk("err_dwait", W'(dwait), W'(2'b11));
      tick();
    end
    ramstate = ACCESS; ramload = 32'hCAFEF00D; #1;
    chk("err_done_dw", W'(dwait), W'(2'b10));
    tick();
    dREN = '0; ramstate = FREE;
    tick();
    tick();
    chk("err_completions", n_obs - obs0, 1);

    // abort: drop dREN mid-transfer, rr stays at 1
    dREN = 2'b01; daddr[0] = 32'h500; ramstate = BUSY;
    tick();
    #1;
    chk("abt_ren", W'(ramREN), 1);
    dREN = '0; #1;
    chk("abt_dwait", W'(dwait), W'(2'b11));
    tick();
    chk("abt_ren_drop", W'(ramREN), 0);
    chk("abt_dwait2", W'(dwait), W'(2'b11));
    dREN = 2'b11; ramstate = ACCESS;
    slot(2'b11, 2'b01);
    dREN = '0;
    tick();

    // asynchronous reset in the middle of a write
    dWEN = 2'b01; daddr[0] = 32'h600; dstore[0] = 32'hABC; ramstate = BUSY;
    tick();
    #1;
    chk("rstx_wen_pre", W'(ramWEN), 1);
    nRST = 1'b0; #1;
    chk("rstx_wen", W'(ramWEN), 0);
    chk("rstx_ren", W'(ramREN), 0);
    chk("rstx_iwait", W'(iwait), W'(2'b11));
    chk("rstx_dwait", W'(dwait), W'(2'b11));
    chk("rstx_addr", ramaddr, 0);
    m_busy = 0; m_rr = 0;
    nRST = 1'b1; dWEN = '0;
    tick();
    dREN = 2'b11; ramstate = ACCESS;
    slot(2'b11, 2'b10);
    dREN = '0;
    tick();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < CPUS; c++) begin
        if ($urandom_range(0, 3) == 0) begin
          r = $urandom_range(0, 7);
          iREN[c]   = r[0];
          dREN[c]   = r[1];
          dWEN[c]   = r[2] && ($urandom_range(0, 1) == 1);
          iaddr[c]  = $urandom;
          daddr[c]  = $urandom;
          dstore[c] = $urandom;
        end
      end
      r = $urandom_range(0, 99);
      if (r < 10)      ramstate = FREE;
      else if (r < 45) ramstate = BUSY;
      else if (r < 85) ramstate = ACCESS;
      else             ramstate = ERROR;
      ramload = $urandom;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-core memory arbiter between the multicore processor's cache request ports and the single-ported `ram` model. It collects instruction and data requests from both cores, grants exactly one at a time, and drives the RAM-side `ramREN`/`ramWEN`/`ramaddr`/`ramstore`. It also returns `ramload` and per-source wait signals to the caches. It sits directly upstream of the testbench/RAM control mux in `system`, on `CPUCLK`.

## Interface

Parameters:
- `CPUS`, 2: number of cores; the arbitration pointer is `$clog2(CPUS)` bits.
- `WORD_W`, 32: width of address and data words (`word_t`).

Ports:
- `CLK`, in, 1: CPU clock (`CPUCLK`).
- `nRST`, in, 1: asynchronous, active-low reset.
- `iREN`, in, CPUS: instruction read request, one bit per core.
- `dREN`, in, CPUS: data read request, one bit per core.
- `dWEN`, in, CPUS: data write request, one bit per core.
- `iaddr`, in, CPUS×WORD_W: instruction address per core.
- `daddr`, in, CPUS×WORD_W: data address per core.
- `dstore`, in, CPUS×WORD_W: write data per core.
- `iwait`, out, CPUS: 1 = instruction request not complete.
- `dwait`, out, CPUS: 1 = data request not complete.
- `iload`, out, CPUS×WORD_W: read data, instruction side.
- `dload`, out, CPUS×WORD_W: read data, data side.
- `ramREN`, out, 1: RAM read enable.
- `ramWEN`, out, 1: RAM write enable.
- `ramaddr`, out, WORD_W: RAM address.
- `ramstore`, out, WORD_W: RAM write data.
- `ramload`, in, WORD_W: RAM read data.
- `ramstate`, in, `ramstate_t`: FREE, BUSY, ACCESS or ERROR.

## Operation

- FSM states are IDLE and XFER.
- **Reset values:**
  - state = IDLE; priority pointer `rr` = 0.
  - `ramREN` = 0, `ramWEN` = 0, `ramaddr` = 0, `ramstore` = 0.
  - all `iwait`/`dwait` = 1; `iload`/`dload` = 0.
- **IDLE:**
  - Sample all requests. Candidate cores are scanned starting at `rr`, wrapping.
  - The first core with any request wins.
  - Within that core, data beats instruction.
  - If `dWEN` and `dREN` are both set, treat it as a write.
  - Latch source {core, i/d, rd/wr}, address, and store data into grant registers; go to XFER.
  - With no requests, stay in IDLE.
- **XFER:**
  - Drive the RAM from the grant registers only. Registered outputs stay stable regardless of requester input changes.
  - `ramstate` FREE/BUSY: hold.
  - `ramstate` ERROR: hold and reissue. The request stays asserted; no completion is signalled.
  - `ramstate` ACCESS:
    - Combinationally clear the granted source's wait bit this cycle.
    - For reads, the matching `iload`/`dload` lane = `ramload`.
    - On the edge: return to IDLE, set `rr` = granted core + 1 (mod CPUS), and drop the RAM enables.
  - Abort: if the granted source's enable is deasserted while in XFER, drop the RAM enables on the next edge and return to IDLE. No wait bit is cleared and `rr` is unchanged.
- Non-granted wait bits stay 1 at all times.
- Load lanes of non-granted sources hold 0.

## Timing

- Request visible at edge N → grant at edge N. RAM enables are high from cycle N+1.
- Completion: with RAM latency L cycles (ACCESS in cycle N+L), wait is low during cycle N+L and the cache samples at edge N+L+1.
- There is one mandatory IDLE cycle between consecutive grants, so minimum occupancy is 2 cycles per access.
- Fairness: two continuously requesting cores alternate grants.
- Worst-case wait per core is one other access plus its own.
- Reset asserted mid-XFER drops all RAM enables and raises all wait bits immediately (asynchronously). No partial write completes on the arbiter side.
- `rr` wraps from CPUS-1 to 0.

## Structure

- Add `ramstate_t` (FREE, BUSY, ACCESS, ERROR), `word_t`, and the FSM enum `arb_state_t` {IDLE, XFER} to `cpu_types_pkg`.
- Add a `cpu_ram_if`-compatible modport `arb` if the interface form is used.
- One sub-module: `rr_picker`, a combinational round-robin priority selector. It takes the request vector and `rr`, and returns the winner index and a valid bit.

## Test plan

- **Single read:** core0 `iREN`=1, `iaddr`=0x40, RAM latency 2, `ramload`=0xDEADBEEF.
  - `ramREN`=1 and `ramaddr`=0x40 from the cycle after the request.
  - `iwait[0]`=0 and `iload[0]`=0xDEADBEEF in the ACCESS cycle only.
- **Contention:** `dREN` on both cores, with `rr`=0.
  - Core0 is served first, then core1 after one IDLE cycle.
  - Repeat the contention: core1 is served first.
- **Same-core priority:** core1 `iREN` and `dWEN` (`daddr`=0x200, `dstore`=0x1234).
  - The write is issued first with `ramWEN`=1 and `ramstore`=0x1234.
  - The fetch follows.
- **Error retry:** `ramstate` = ERROR for 3 cycles, then ACCESS.
  - `ramREN` held throughout and `ramaddr` unchanged.
  - Exactly one completion.
- **Abort and reset:**
  - Drop `dREN` mid-XFER: enables fall at the next edge, `dwait` stays 1, and `rr` is unchanged.
  - Pulse `nRST` low mid-XFER: `ramWEN`=0 immediately, all wait bits = 1, and the FSM is in IDLE.
